// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory (M) pipeline stage: opcodes, byte-enable
// encodings, default geometry and the byte-merge helper used by the data RAM.
package memory_stage_pkg;

    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    localparam int          DM_WORDS_DEF   = 1024;
    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_0FFF;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Byte-enabled data RAM: synchronous write, asynchronous read of the addressed
// word (so a same-edge capture sees pre-write data), asynchronous clear.
module dm_ram
    import memory_stage_pkg::*;
#(
    parameter int WORDS = DM_WORDS_DEF,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    // Storage array: cleared on reset, enabled bytes merged on a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= merge_bytes(mem_q[addr_i], wdata_i, be_i);
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// M pipeline stage: load/store decode, alignment/range check, store lane
// steering, data RAM and the M/W register. Define MEMORY_STAGE_DISPLAY_EN to
// print every committed store.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int          DM_WORDS   = DM_WORDS_DEF,
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC3,
    input  logic [31:0] Instr3,
    input  logic [31:0] Result3,
    input  logic [31:0] WriteData3,
    input  logic        Flush3,
    output logic [31:0] PC4,
    output logic [31:0] Instr4,
    output logic [31:0] Result4,
    output logic [31:0] RD4,
    output logic        AddrErr4
);

    localparam int AW = $clog2(DM_WORDS);

    acc_size_e   size_s;
    logic        is_store_s;
    logic        is_load_s;
    logic        misalign_s;
    logic        out_of_range_s;
    logic        addr_err_s;
    logic        we_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] rd_word_s;
    logic [AW-1:0] word_idx_s;

    logic [31:0] pc_d, instr_d, result_d, rd_d;
    logic        err_d;
    logic [31:0] pc_q, instr_q, result_q, rd_q;
    logic        err_q;

    assign word_idx_s = Result3[AW+1:2];

    // Opcode decode into access class and size.
    always_comb begin
        size_s     = SZ_NONE;
        is_store_s = 1'b0;
        is_load_s  = 1'b0;
        case (Instr3[31:26])
            OP_SW:                 begin is_store_s = 1'b1; size_s = SZ_WORD; end
            OP_SH:                 begin is_store_s = 1'b1; size_s = SZ_HALF; end
            OP_SB:                 begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            OP_LW:                 begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            OP_LH, OP_LHU:         begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            OP_LB, OP_LBU:         begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            default:               begin is_store_s = 1'b0; is_load_s = 1'b0; end
        endcase
    end

    // Alignment check, byte enables and lane-replicated store data.
    always_comb begin
        misalign_s = 1'b0;
        be_s       = BE_NONE;
        wdata_s    = WriteData3;
        case (size_s)
            SZ_WORD: begin
                misalign_s = (Result3[1:0] != 2'b00);
                be_s       = BE_WORD;
            end
            SZ_HALF: begin
                misalign_s = Result3[0];
                be_s       = Result3[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_s    = {2{WriteData3[15:0]}};
            end
            SZ_BYTE: begin
                be_s    = BE_BYTE0 << Result3[1:0];
                wdata_s = {4{WriteData3[7:0]}};
            end
            default: begin
                misalign_s = 1'b0;
            end
        endcase
    end

    assign out_of_range_s = (Result3 > ADDR_LIMIT);
    assign addr_err_s     = (is_store_s | is_load_s) & (misalign_s | out_of_range_s);
    assign we_s           = is_store_s & ~addr_err_s & ~Flush3 & ~reset;

    dm_ram #(
        .WORDS (DM_WORDS),
        .AW    (AW)
    ) u_dm_ram (
        .clk     (clk),
        .rst     (reset),
        .we_i    (we_s),
        .addr_i  (word_idx_s),
        .be_i    (be_s),
        .wdata_i (wdata_s),
        .rdata_o (rd_word_s)
    );

    // M/W register next state: a flush loads a bubble.
    always_comb begin
        pc_d     = PC3;
        instr_d  = Instr3;
        result_d = Result3;
        rd_d     = rd_word_s;
        err_d    = addr_err_s;
        if (Flush3) begin
            pc_d     = 32'h0000_0000;
            instr_d  = 32'h0000_0000;
            result_d = 32'h0000_0000;
            rd_d     = 32'h0000_0000;
            err_d    = 1'b0;
        end else begin
            err_d    = addr_err_s;
        end
    end

    // M/W pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 32'h0000_0000;
            instr_q  <= 32'h0000_0000;
            result_q <= 32'h0000_0000;
            rd_q     <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

`ifdef MEMORY_STAGE_DISPLAY_EN
    // Store trace: PC, word-aligned byte address, merged word.
    always_ff @(posedge clk) begin
        if (we_s) begin
            $display("@%h: *%h <= %h", PC3, {Result3[31:2], 2'b00},
                     merge_bytes(rd_word_s, wdata_s, be_s));
        end
    end
`endif

    assign PC4      = pc_q;
    assign Instr4   = instr_q;
    assign Result4  = result_q;
    assign RD4      = rd_q;
    assign AddrErr4 = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed table-driven bench for memory_stage, plus reset corner sequences.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [31:0] PC3, Instr3, Result3, WriteData3;
    logic        Flush3;
    logic [31:0] PC4, Instr4, Result4, RD4;
    logic        AddrErr4;

    int checks;
    int errors;
    logic [31:0] pc_ctr;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        flush;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [26];

    memory_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PC3        (PC3),
        .Instr3     (Instr3),
        .Result3    (Result3),
        .WriteData3 (WriteData3),
        .Flush3     (Flush3),
        .PC4        (PC4),
        .Instr4     (Instr4),
        .Result4    (Result4),
        .RD4        (RD4),
        .AddrErr4   (AddrErr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        PC3        = pc_ctr;
        Instr3     = {t.op, 26'h0ABCDE};
        Result3    = t.addr;
        WriteData3 = t.wd;
        Flush3     = t.flush;
    endtask

    // Drive one M-stage instruction, clock it, check the W-stage outputs.
    task automatic apply(input vec_t t, input string name);
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_res;
        drive(t);
        exp_instr = t.flush ? 32'h0 : {t.op, 26'h0ABCDE};
        exp_pc    = t.flush ? 32'h0 : pc_ctr;
        exp_res   = t.flush ? 32'h0 : t.addr;
        @(posedge clk);
        #1;
        chk({name, ".RD4"},      RD4,             t.exp_rd);
        chk({name, ".AddrErr4"}, {31'h0, AddrErr4}, {31'h0, t.exp_err});
        chk({name, ".Instr4"},   Instr4,          exp_instr);
        chk({name, ".PC4"},      PC4,             exp_pc);
        chk({name, ".Result4"},  Result4,         exp_res);
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".PC4"},      PC4,     32'h0);
        chk({name, ".Instr4"},   Instr4,  32'h0);
        chk({name, ".Result4"},  Result4, 32'h0);
        chk({name, ".RD4"},      RD4,     32'h0);
        chk({name, ".AddrErr4"}, {31'h0, AddrErr4}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc_ctr = 32'h0040_0000;

        //            op      addr          wdata         fl    exp RD4       err
        vecs[0]  = '{6'h2B, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{6'h23, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{6'h2B, 32'h0000_0020, 32'h11223344, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{6'h28, 32'h0000_0022, 32'h123456AA, 1'b0, 32'h11223344, 1'b0};
        vecs[4]  = '{6'h23, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h11AA3344, 1'b0};
        vecs[5]  = '{6'h29, 32'h0000_0032, 32'hCAFEBEEF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{6'h23, 32'h0000_0030, 32'h0000_0000, 1'b0, 32'hBEEF0000, 1'b0};
        vecs[7]  = '{6'h29, 32'h0000_0031, 32'h00001234, 1'b0, 32'hBEEF0000, 1'b1};
        vecs[8]  = '{6'h23, 32'h0000_0030, 32'h0000_0000, 1'b0, 32'hBEEF0000, 1'b0};
        vecs[9]  = '{6'h2B, 32'h0000_1000, 32'h00000099, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{6'h23, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[11] = '{6'h2B, 32'h0000_0040, 32'h00000005, 1'b1, 32'h0000_0000, 1'b0};
        vecs[12] = '{6'h23, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[13] = '{6'h29, 32'h0000_0031, 32'h00005555, 1'b1, 32'h0000_0000, 1'b0};
        vecs[14] = '{6'h23, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[15] = '{6'h21, 32'h0000_0033, 32'h0000_0000, 1'b0, 32'hBEEF0000, 1'b1};
        vecs[16] = '{6'h25, 32'h0000_0032, 32'h0000_0000, 1'b0, 32'hBEEF0000, 1'b0};
        vecs[17] = '{6'h20, 32'h0000_0021, 32'h0000_0000, 1'b0, 32'h11AA3344, 1'b0};
        vecs[18] = '{6'h00, 32'h0002_0000, 32'hFFFFFFFF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[19] = '{6'h28, 32'h0000_0013, 32'h00000077, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[20] = '{6'h23, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h77ADBEEF, 1'b0};
        vecs[21] = '{6'h2B, 32'h0000_0FFC, 32'hA5A5A5A5, 1'b0, 32'h0000_0000, 1'b0};
        vecs[22] = '{6'h23, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[23] = '{6'h24, 32'h0000_1000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[24] = '{6'h28, 32'h0000_0FFF, 32'h0000003C, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[25] = '{6'h23, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'h3CA5A5A5, 1'b0};

        reset      = 1'b1;
        PC3        = 32'h0;
        Instr3     = 32'h0;
        Result3    = 32'h0;
        WriteData3 = 32'h0;
        Flush3     = 1'b0;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-cycle with a store pending: clears asynchronously
        // and the store is discarded.
        drive('{6'h2B, 32'h0000_0050, 32'h0BADF00D, 1'b0, 32'h0, 1'b0});
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("held_reset");
        reset = 1'b0;

        apply('{6'h23, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_0000, 1'b0}, "post_rst_lw10");
        apply('{6'h23, 32'h0000_0050, 32'h0, 1'b0, 32'h0000_0000, 1'b0}, "post_rst_lw50");
        apply('{6'h23, 32'h0000_0FFC, 32'h0, 1'b0, 32'h0000_0000, 1'b0}, "post_rst_lwffc");
        apply('{6'h2B, 32'h0000_0060, 32'hCAFE0001, 1'b0, 32'h0000_0000, 1'b0}, "post_rst_sw60");
        apply('{6'h23, 32'h0000_0060, 32'h0, 1'b0, 32'hCAFE0001, 1'b0}, "post_rst_lw60");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
